// File: rtl/obtener_trama_if.sv
// Byte-stream input and framed-field output bundle for obtener_trama.
interface obtener_trama_if #(
  parameter int unsigned N_BYTES = 6
);
  logic [7:0]           dato;
  logic                 dato_valid;
  logic                 enable;
  logic [8*N_BYTES-1:0] trama;
  logic                 trama_valid;
  logic                 error;
  logic [2:0]           err_code;
  logic                 busy;
  logic [7:0]           cnt_tramas;

  modport master (
    output dato, dato_valid, enable,
    input  trama, trama_valid, error, err_code, busy, cnt_tramas
  );

  modport slave (
    input  dato, dato_valid, enable,
    output trama, trama_valid, error, err_code, busy, cnt_tramas
  );
endinterface

// File: rtl/obtener_trama.sv
// Framed-field capture: DELIM, N_BYTES payload bytes, DELIM -> wide trama register.
// Optional OBTENER_TRAMA_DIGIT_CHECK_EN rejects non-digit payload bytes with BAD_CHAR.
module obtener_trama #(
  parameter int unsigned N_BYTES     = 6,
  parameter logic [7:0]  DELIM       = 8'd90,
  parameter int unsigned TIMEOUT_CYC = 50_000,
  parameter bit          ONE_SHOT    = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  obtener_trama_if.slave bus
);

  localparam int unsigned W  = 8 * N_BYTES;
  localparam int unsigned CW = $clog2(N_BYTES + 1);
  localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

  localparam logic [2:0] ERR_SHORT    = 3'd1;
  localparam logic [2:0] ERR_LONG     = 3'd2;
  localparam logic [2:0] ERR_TIMEOUT  = 3'd3;
`ifdef OBTENER_TRAMA_DIGIT_CHECK_EN
  localparam logic [2:0] ERR_BAD_CHAR = 3'd4;
`endif

  typedef enum logic [1:0] {IDLE, RECV, WAIT_END} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            lock_q, lock_d;
  logic [W-1:0]    stage_q, stage_d;
  logic [W-1:0]    trama_q, trama_d;
  logic            trama_valid_q, trama_valid_d;
  logic            error_q, error_d;
  logic [2:0]      err_code_q, err_code_d;
  logic            busy_q, busy_d;
  logic [7:0]      cnt_tramas_q, cnt_tramas_d;
  logic            timeout_hit_c;

  // A strobe on the expiry cycle wins over the timeout.
  assign timeout_hit_c = (TIMEOUT_CYC != 0) && !bus.dato_valid &&
                         (timer_q + TW'(1) == TW'(TIMEOUT_CYC));

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    timer_d       = timer_q;
    lock_d        = lock_q;
    stage_d       = stage_q;
    trama_d       = trama_q;
    trama_valid_d = 1'b0;
    error_d       = 1'b0;
    err_code_d    = err_code_q;
    cnt_tramas_d  = cnt_tramas_q;

    unique case (state_q)
      IDLE: begin
        cnt_d   = '0;
        timer_d = '0;
        if (bus.dato_valid && bus.dato == DELIM && !lock_q) begin
          state_d = RECV;
        end
      end

      RECV: begin
        if (bus.dato_valid) begin
          timer_d = '0;
          if (bus.dato == 8'h00) begin
            // filler byte: keeps the frame alive, not stored
          end else if (bus.dato == DELIM) begin
            error_d    = 1'b1;
            err_code_d = ERR_SHORT;
            cnt_d      = '0;
          end
`ifdef OBTENER_TRAMA_DIGIT_CHECK_EN
          else if (bus.dato < 8'h30 || bus.dato > 8'h39) begin
            error_d    = 1'b1;
            err_code_d = ERR_BAD_CHAR;
            state_d    = IDLE;
          end
`endif
          else begin
            // Shift in at the top so the first byte lands in [7:0].
            stage_d = {bus.dato, stage_q[W-1:8]};
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q + CW'(1) == CW'(N_BYTES)) state_d = WAIT_END;
          end
        end else if (timeout_hit_c) begin
          error_d    = 1'b1;
          err_code_d = ERR_TIMEOUT;
          state_d    = IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      WAIT_END: begin
        if (bus.dato_valid) begin
          state_d = IDLE;
          if (bus.dato == DELIM) begin
            trama_d       = stage_q;
            trama_valid_d = 1'b1;
            cnt_tramas_d  = cnt_tramas_q + 8'd1;
            lock_d        = ONE_SHOT;
          end else begin
            error_d    = 1'b1;
            err_code_d = ERR_LONG;
          end
        end else if (timeout_hit_c) begin
          error_d    = 1'b1;
          err_code_d = ERR_TIMEOUT;
          state_d    = IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      default: state_d = IDLE;
    endcase

    // Soft reset: trama, err_code and cnt_tramas survive.
    if (!bus.enable) begin
      state_d       = IDLE;
      cnt_d         = '0;
      timer_d       = '0;
      lock_d        = 1'b0;
      trama_d       = trama_q;
      trama_valid_d = 1'b0;
      error_d       = 1'b0;
      err_code_d    = err_code_q;
      cnt_tramas_d  = cnt_tramas_q;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      timer_q       <= '0;
      lock_q        <= 1'b0;
      stage_q       <= '0;
      trama_q       <= {N_BYTES{8'h30}};
      trama_valid_q <= 1'b0;
      error_q       <= 1'b0;
      err_code_q    <= 3'd0;
      busy_q        <= 1'b0;
      cnt_tramas_q  <= 8'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      timer_q       <= timer_d;
      lock_q        <= lock_d;
      stage_q       <= stage_d;
      trama_q       <= trama_d;
      trama_valid_q <= trama_valid_d;
      error_q       <= error_d;
      err_code_q    <= err_code_d;
      busy_q        <= busy_d;
      cnt_tramas_q  <= cnt_tramas_d;
    end
  end

  assign bus.trama       = trama_q;
  assign bus.trama_valid = trama_valid_q;
  assign bus.error       = error_q;
  assign bus.err_code    = err_code_q;
  assign bus.busy        = busy_q;
  assign bus.cnt_tramas  = cnt_tramas_q;

endmodule

// File: tb/tb_obtener_trama.sv
// Directed bench for obtener_trama: u0 runs continuous mode, u1 one-shot mode.
module tb_obtener_trama;

  localparam int unsigned TO = 40;
  localparam logic [7:0]  Z  = 8'd90;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [7:0] exp_cnt;

  obtener_trama_if #(.N_BYTES(6)) if0 ();
  obtener_trama_if #(.N_BYTES(6)) if1 ();

  obtener_trama #(.N_BYTES(6), .DELIM(Z), .TIMEOUT_CYC(TO), .ONE_SHOT(1'b0)) u0 (
    .clk(clk), .rst(rst), .bus(if0)
  );
  obtener_trama #(.N_BYTES(6), .DELIM(Z), .TIMEOUT_CYC(TO), .ONE_SHOT(1'b1)) u1 (
    .clk(clk), .rst(rst), .bus(if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int u, input logic [7:0] b);
    if (u == 0) begin
      if0.dato = b; if0.dato_valid = 1'b1;
    end else begin
      if1.dato = b; if1.dato_valid = 1'b1;
    end
    @(posedge clk);
    #1;
    if0.dato_valid = 1'b0;
    if1.dato_valid = 1'b0;
  endtask

  // Delimiter, six payload bytes (p[7:0] first), closing delimiter.
  task automatic frame(input int u, input logic [47:0] p);
    send(u, Z);
    for (int i = 0; i < 6; i++) send(u, p[8*i +: 8]);
    send(u, Z);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp_cnt = 8'd0;
    rst = 1'b1;
    if0.dato = 8'h00; if0.dato_valid = 1'b0; if0.enable = 1'b1;
    if1.dato = 8'h00; if1.dato_valid = 1'b0; if1.enable = 1'b1;
    idle(2);

    check("rst_trama", 64'(if0.trama), 64'h303030303030);
    check("rst_tv", 64'(if0.trama_valid), 64'd0);
    check("rst_err", 64'(if0.error), 64'd0);
    check("rst_code", 64'(if0.err_code), 64'd0);
    check("rst_busy", 64'(if0.busy), 64'd0);
    check("rst_cnt", 64'(if0.cnt_tramas), 64'd0);
    rst = 1'b0;
    idle(1);

    // Basic commit
    send(0, Z);
    check("busy_after_z", 64'(if0.busy), 64'd1);
    for (int i = 0; i < 6; i++) send(0, 8'h31 + 8'(i));
    send(0, Z);
    exp_cnt = 8'd1;
    check("f1_tv", 64'(if0.trama_valid), 64'd1);
    check("f1_trama", 64'(if0.trama), 64'h363534333231);
    check("f1_cnt", 64'(if0.cnt_tramas), 64'd1);
    check("f1_busy", 64'(if0.busy), 64'd0);
    idle(1);
    check("f1_tv_drop", 64'(if0.trama_valid), 64'd0);

    // SHORT then restarted frame commits
    send(0, Z); send(0, "1"); send(0, "2"); send(0, Z);
    check("short_err", 64'(if0.error), 64'd1);
    check("short_code", 64'(if0.err_code), 64'd1);
    check("short_busy", 64'(if0.busy), 64'd1);
    send(0, "0");
    check("short_err_drop", 64'(if0.error), 64'd0);
    send(0, "9"); send(0, "3"); send(0, "0"); send(0, "0"); send(0, "0"); send(0, Z);
    exp_cnt = 8'd2;
    check("f2_tv", 64'(if0.trama_valid), 64'd1);
    check("f2_trama", 64'(if0.trama), 64'h303030333930);
    check("f2_cnt", 64'(if0.cnt_tramas), 64'd2);

    // LONG error leaves trama untouched
    send(0, Z);
    for (int i = 0; i < 6; i++) send(0, 8'h31 + 8'(i));
    send(0, "7");
    check("long_err", 64'(if0.error), 64'd1);
    check("long_code", 64'(if0.err_code), 64'd2);
    check("long_trama", 64'(if0.trama), 64'h303030333930);
    check("long_busy", 64'(if0.busy), 64'd0);

    // 0x00 inside a frame is skipped
    send(0, Z); send(0, "1"); send(0, 8'h00);
    for (int i = 1; i < 6; i++) send(0, 8'h31 + 8'(i));
    send(0, Z);
    exp_cnt = 8'd3;
    check("nul_trama", 64'(if0.trama), 64'h363534333231);
    check("nul_cnt", 64'(if0.cnt_tramas), 64'd3);

    // Timeout exactly at TO idle cycles
    send(0, Z); send(0, "1");
    idle(TO - 1);
    check("to_pre_err", 64'(if0.error), 64'd0);
    check("to_pre_busy", 64'(if0.busy), 64'd1);
    idle(1);
    check("to_err", 64'(if0.error), 64'd1);
    check("to_code", 64'(if0.err_code), 64'd3);
    check("to_busy", 64'(if0.busy), 64'd0);

    // Strobe on the expiry cycle wins
    send(0, Z); send(0, "1");
    idle(TO - 1);
    send(0, "2");
    check("to_race_err", 64'(if0.error), 64'd0);
    check("to_race_busy", 64'(if0.busy), 64'd1);
    idle(TO - 1);
    check("to_race_pre", 64'(if0.error), 64'd0);
    idle(1);
    check("to_race_late", 64'(if0.error), 64'd1);

`ifdef OBTENER_TRAMA_DIGIT_CHECK_EN
    send(0, Z); send(0, "1"); send(0, "A");
    check("bad_err", 64'(if0.error), 64'd1);
    check("bad_code", 64'(if0.err_code), 64'd4);
    check("bad_busy", 64'(if0.busy), 64'd0);
`else
    frame(0, 48'h464544434241);
    exp_cnt = 8'd4;
    check("alpha_tv", 64'(if0.trama_valid), 64'd1);
    check("alpha_trama", 64'(if0.trama), 64'h464544434241);
`endif

    // Counter wrap
    while (exp_cnt != 8'd255) begin
      frame(0, 48'h313233343536);
      exp_cnt = exp_cnt + 8'd1;
    end
    check("cnt_255", 64'(if0.cnt_tramas), 64'd255);
    frame(0, 48'h393837363534);
    check("cnt_wrap", 64'(if0.cnt_tramas), 64'd0);
    check("wrap_trama", 64'(if0.trama), 64'h393837363534);

    // enable low aborts a frame and keeps the retained outputs
    send(0, Z); send(0, "1"); send(0, "2");
    if0.enable = 1'b0;
    idle(1);
    if0.enable = 1'b1;
    check("en_busy", 64'(if0.busy), 64'd0);
    check("en_cnt", 64'(if0.cnt_tramas), 64'd0);
    check("en_code", 64'(if0.err_code), 64'd3);
    check("en_trama", 64'(if0.trama), 64'h393837363534);
    for (int i = 2; i < 6; i++) send(0, 8'h31 + 8'(i));
    check("en_no_busy", 64'(if0.busy), 64'd0);

    // One-shot behaviour on u1
    send(1, Z);
    for (int i = 0; i < 6; i++) send(1, 8'h31 + 8'(i));
    send(1, "7");
    check("os_long_code", 64'(if1.err_code), 64'd2);
    check("os_long_trama", 64'(if1.trama), 64'h303030303030);
    frame(1, 48'h313131313131);
    check("os_f1_tv", 64'(if1.trama_valid), 64'd1);
    check("os_f1_trama", 64'(if1.trama), 64'h313131313131);
    check("os_f1_cnt", 64'(if1.cnt_tramas), 64'd1);
    send(1, Z);
    check("os_locked_busy", 64'(if1.busy), 64'd0);
    for (int i = 0; i < 6; i++) send(1, "2");
    send(1, Z);
    check("os_locked_tv", 64'(if1.trama_valid), 64'd0);
    check("os_locked_trama", 64'(if1.trama), 64'h313131313131);
    check("os_locked_cnt", 64'(if1.cnt_tramas), 64'd1);
    if1.enable = 1'b0;
    idle(1);
    if1.enable = 1'b1;
    check("os_en_cnt", 64'(if1.cnt_tramas), 64'd1);
    frame(1, 48'h333333333333);
    check("os_f3_tv", 64'(if1.trama_valid), 64'd1);
    check("os_f3_trama", 64'(if1.trama), 64'h333333333333);
    check("os_f3_cnt", 64'(if1.cnt_tramas), 64'd2);

    // Reset mid-frame
    send(0, Z); send(0, "1"); send(0, "2");
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check("mrst_trama", 64'(if0.trama), 64'h303030303030);
    check("mrst_cnt", 64'(if0.cnt_tramas), 64'd0);
    check("mrst_code", 64'(if0.err_code), 64'd0);
    check("mrst_busy", 64'(if0.busy), 64'd0);
    frame(0, 48'h383736353433);
    check("mrst_f_tv", 64'(if0.trama_valid), 64'd1);
    check("mrst_f_trama", 64'(if0.trama), 64'h383736353433);
    check("mrst_f_cnt", 64'(if0.cnt_tramas), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/obtener_trama.md
# obtener_trama

Parametrised framed-field capture block for the byte stream delivered by the receiver. Hunts for a start delimiter, collects exactly `N_BYTES` payload bytes, and requires a closing delimiter before committing them to a wide output register. It adds a per-byte strobe, an inter-byte timeout, error reporting, a frame counter and a one-shot/continuous mode. Sits between the byte receiver and the consumers of the time/setting field.

## Interface
- `N_BYTES`, 6: payload bytes per frame; allowed range 1..16.
- `DELIM`, 8'd90 ('Z'): start and closing delimiter.
- `TIMEOUT_CYC`, 50_000: clk cycles allowed without `dato_valid` while inside a frame; 0 disables the timeout.
- `ONE_SHOT`, 1: 1 = after the first good frame, ignore input until `rst` or until `enable` is low; 0 = capture continuously.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `dato`  in  8  received byte; qualified by `dato_valid`.
- `dato_valid`  in  1  one-cycle strobe per received byte.
- `enable`  in  1  low = force IDLE, clear count/timer/one-shot lock.
- `trama`  out  8*N_BYTES  last committed payload; first received byte in [7:0].
- `trama_valid`  out  1  one-cycle pulse on commit.
- `error`  out  1  one-cycle pulse on a rejected frame.
- `err_code`  out  3  last error: 1 SHORT, 2 LONG, 3 TIMEOUT, 4 BAD_CHAR; held until the next error.
- `busy`  out  1  high in RECV or WAIT_END.
- `cnt_tramas`  out  8  number of good frames; wraps 255→0.

## Operation
- Reset values:
  - `trama` = 0x30 in every byte (ASCII '0').
  - `trama_valid` = 0, `error` = 0, `err_code` = 0, `busy` = 0, `cnt_tramas` = 0.
  - State IDLE; byte count, timer and lock cleared.
- `rst` dominates `enable`. `enable` low acts as a soft reset, except that `trama`, `err_code` and `cnt_tramas` keep their values.
- States:
  - IDLE: on a valid byte equal to `DELIM`, and the lock clear → RECV with count = 0. Any other byte is ignored.
  - RECV:
    - valid 0x00: ignored, not stored, but restarts the timer.
    - valid `DELIM` with count < N: SHORT error; stay in RECV with count = 0 (the delimiter is treated as a new start).
    - any other valid byte: shift it into the staging register at the top, so the first byte ends up in [7:0]; count++.
    - count reaching N → WAIT_END.
  - WAIT_END:
    - valid `DELIM`: `trama` ← staging register, pulse `trama_valid`, `cnt_tramas`++, set the lock if `ONE_SHOT`=1 → IDLE.
    - any other valid byte, including 0x00: LONG error → IDLE.
- Timeout: the timer counts cycles in RECV/WAIT_END and clears on every `dato_valid`. When it reaches `TIMEOUT_CYC` cycles → TIMEOUT error → IDLE.
- Any error aborts the frame and never modifies `trama`.

## Timing
- All inputs are sampled on the rising edge of `clk`. One byte per strobe; back-to-back strobes on consecutive cycles are supported.
- Commit latency: `trama` updates, and `trama_valid` goes high, on the same edge that samples the closing `DELIM`. `trama_valid` is visible for exactly the following cycle.
- `error` and `err_code` update on the edge that detects the fault. `error` is high for exactly one cycle.
- Timeout edge case: if a `dato_valid` coincides with the cycle the timer would expire, the byte wins and no timeout is raised.
- `busy` is registered and follows the state register.
- `cnt_tramas` increments on the commit edge; 255 + 1 = 0.

## Configuration
- `OBTENER_TRAMA_DIGIT_CHECK_EN` defined: in RECV, a valid byte that is non-zero, not `DELIM` and outside 0x30..0x39 raises BAD_CHAR and goes to IDLE.
- Not defined: any non-zero, non-`DELIM` byte is stored. Error code 4 is never produced.

## Test plan
- Stream 'Z','1','2','3','4','5','6','Z' with `ONE_SHOT`=0 → `trama` = 0x363534333231, one `trama_valid` pulse, `cnt_tramas` = 1.
- 'Z','1','2','Z','0','9','3','0','0','0','Z' → SHORT error (`err_code` = 1) on the second 'Z', then commit `trama` = 0x303030333930.
- 'Z' + six digits + '7' → LONG error (`err_code` = 2), `trama` unchanged. A second full frame with `ONE_SHOT`=1 commits; a third frame is ignored until `enable` is pulsed low.
- 'Z','1' then 50_000 idle cycles → TIMEOUT error (`err_code` = 3) exactly at cycle 50_000, `busy` = 0. Repeat with the strobe landing on the expiry cycle → no error.
- With `OBTENER_TRAMA_DIGIT_CHECK_EN`: 'Z','1','A' → BAD_CHAR (`err_code` = 4). Without the macro, 'Z','A','B','C','D','E','F','Z' commits 0x464544434241.
- `rst` asserted mid-frame after 3 bytes → all outputs return to reset values next cycle, and a subsequent full frame commits normally.
